multicycle_control: RTL and testbench

- Multicycle controller for the 16-bit-style processor datapath; one FSM sequences each instruction through fetch, decode, execute, memory and writeback.
- Takes the 4-bit opcode from the instruction register plus a branch-condition bit.
- Drives every datapath write enable and mux select: memory address select, register-file, PC, status-register and compare-code writes, and the ALU operation and operand selects.

---
 rtl/multicycle_control_if.sv | 26 ++
 rtl/multicycle_control.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [3:0] opcode;
    logic       cond;
    logic       IorD;
    logic       memw;
    logic       regw;
    logic       pcw;
    logic       srw;
    logic [1:0] aluop;
    logic [1:0] regop;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic       compcodew;

    modport master (
        input  opcode, cond,
        output IorD, memw, regw, pcw, srw, aluop, regop, aluSrcA, aluSrcB, compcodew
    );

    modport slave (
        output opcode, cond,
        input  IorD, memw, regw, pcw, srw, aluop, regop, aluSrcA, aluSrcB, compcodew
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: FETCH/DECODE/execute/memory/writeback control FSM.
// Latency 2-5 cycles per instruction; Moore outputs except BRANCH pcw (follows cond).
// No backpressure; CTRL_DEBUG_EN adds dbg_state/dbg_illegal ports.
module multicycle_control (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
`ifdef CTRL_DEBUG_EN
    ,
    output logic [3:0]           dbg_state,
    output logic                 dbg_illegal
`endif
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_CMP    = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_LI     = 4'd11;

    localparam logic [3:0] OP_LW   = 4'b0000;
    localparam logic [3:0] OP_SW   = 4'b0001;
    localparam logic [3:0] OP_LI   = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1000;
    localparam logic [3:0] OP_BR   = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1010;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [3:0] op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            op_q  <= 4'b0000;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                op_q <= bus.opcode;
        end
    end

    // DECODE steers on the live opcode; later states use the latched copy.
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:                          state_nxt = S_MEMADR;
                    OP_ADDI, OP_ADD, OP_SUB, OP_AND, OP_OR: state_nxt = S_EXEC;
                    OP_CMP:                                state_nxt = S_CMP;
                    OP_BR:                                 state_nxt = S_BRANCH;
                    OP_JMP:                                state_nxt = S_JUMP;
                    OP_LI:                                 state_nxt = S_LI;
                    default:                               state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_EXEC:   state_nxt = S_ALUWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    logic       iord_c, memw_c, regw_c, pcw_c, srw_c, ccw_c;
    logic [1:0] aluop_c, regop_c, srca_c, srcb_c;

    // Outputs are forced low while reset is held, even though FETCH is the reset state.
    always_comb begin
        iord_c  = 1'b0;
        memw_c  = 1'b0;
        regw_c  = 1'b0;
        pcw_c   = 1'b0;
        srw_c   = 1'b0;
        ccw_c   = 1'b0;
        aluop_c = 2'b00;
        regop_c = 2'b00;
        srca_c  = 2'b00;
        srcb_c  = 2'b00;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    srcb_c = 2'b01;
                    pcw_c  = 1'b1;
                end
                S_MEMADR: begin
                    srca_c = 2'b01;
                    srcb_c = 2'b10;
                end
                S_MEMRD:  iord_c = 1'b1;
                S_MEMWB: begin
                    regw_c  = 1'b1;
                    regop_c = 2'b01;
                end
                S_MEMWR: begin
                    iord_c = 1'b1;
                    memw_c = 1'b1;
                end
                S_EXEC: begin
                    srca_c = 2'b01;
                    srw_c  = 1'b1;
                    srcb_c = (op_q == OP_ADDI) ? 2'b10 : 2'b00;
                    case (op_q)
                        OP_SUB:  aluop_c = 2'b01;
                        OP_AND:  aluop_c = 2'b10;
                        OP_OR:   aluop_c = 2'b11;
                        default: aluop_c = 2'b00;
                    endcase
                end
                S_ALUWB:  regw_c = 1'b1;
                S_CMP: begin
                    srca_c  = 2'b01;
                    aluop_c = 2'b01;
                    srw_c   = 1'b1;
                    ccw_c   = 1'b1;
                end
                S_BRANCH: begin
                    srcb_c = 2'b10;
                    pcw_c  = bus.cond;
                end
                S_JUMP: begin
                    srca_c = 2'b10;
                    srcb_c = 2'b10;
                    pcw_c  = 1'b1;
                end
                S_LI: begin
                    regw_c  = 1'b1;
                    regop_c = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign bus.IorD      = iord_c;
    assign bus.memw      = memw_c;
    assign bus.regw      = regw_c;
    assign bus.pcw       = pcw_c;
    assign bus.srw       = srw_c;
    assign bus.aluop     = aluop_c;
    assign bus.regop     = regop_c;
    assign bus.aluSrcA   = srca_c;
    assign bus.aluSrcB   = srcb_c;
    assign bus.compcodew = ccw_c;

`ifdef CTRL_DEBUG_EN
    assign dbg_state   = state;
    assign dbg_illegal = (state == S_DECODE) && (bus.opcode > OP_JMP);
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed then random instruction stream against
// a per-instruction cycle table built from the opcode map.
module tb_multicycle_control;
    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    multicycle_control_if bus();

`ifdef CTRL_DEBUG_EN
    logic [3:0] dbg_state;
    logic       dbg_illegal;
    multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                            .dbg_state(dbg_state), .dbg_illegal(dbg_illegal));
`else
    multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IorD, memw, regw, pcw, srw, aluop, regop, aluSrcA, aluSrcB, compcodew}
    logic [13:0] obs;
    assign obs = {bus.IorD, bus.memw, bus.regw, bus.pcw, bus.srw, bus.aluop,
                  bus.regop, bus.aluSrcA, bus.aluSrcB, bus.compcodew};

    function automatic logic [13:0] mk(input logic iord, input logic memw, input logic regw,
                                       input logic pcw, input logic srw, input logic [1:0] aluop,
                                       input logic [1:0] regop, input logic [1:0] srca,
                                       input logic [1:0] srcb, input logic ccw);
        return {iord, memw, regw, pcw, srw, aluop, regop, srca, srcb, ccw};
    endfunction

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_inv(input string tag);
        checks++;
        assert ((bus.memw & bus.regw) === 1'b0 && (!bus.memw || bus.IorD) === 1'b1) else begin
            fails++;
            $error("FAIL %s: observed memw=%b regw=%b IorD=%b expected no overlap and memw->IorD",
                   tag, bus.memw, bus.regw, bus.IorD);
        end
    endtask

    // Expected per-cycle outputs of one instruction, FETCH first; entry time is just after a rising edge.
    task automatic run_instr(input logic [3:0] op, input logic c, input int abort_at);
        logic [13:0] q[$];
        logic [1:0]  aop;
        string       tag;
        q = {};
        q.push_back(mk(0,0,0,1,0,2'b00,2'b00,2'b00,2'b01,0));
        q.push_back(14'd0);
        if (op <= 4'd1) begin
            q.push_back(mk(0,0,0,0,0,2'b00,2'b00,2'b01,2'b10,0));
            if (op == 4'd0) begin
                q.push_back(mk(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
                q.push_back(mk(0,0,1,0,0,2'b00,2'b01,2'b00,2'b00,0));
            end else begin
                q.push_back(mk(1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
            end
        end else if (op >= 4'd3 && op <= 4'd7) begin
            aop = (op == 4'd3) ? 2'b00 : 2'(op - 4'd4);
            q.push_back(mk(0,0,0,0,1,aop,2'b00,2'b01,(op == 4'd3) ? 2'b10 : 2'b00,0));
            q.push_back(mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0));
        end else if (op == 4'd8) begin
            q.push_back(mk(0,0,0,0,1,2'b01,2'b00,2'b01,2'b00,1));
        end else if (op == 4'd9) begin
            q.push_back(mk(0,0,0,c,0,2'b00,2'b00,2'b00,2'b10,0));
        end else if (op == 4'd10) begin
            q.push_back(mk(0,0,0,1,0,2'b00,2'b00,2'b10,2'b10,0));
        end else if (op == 4'd2) begin
            q.push_back(mk(0,0,1,0,0,2'b00,2'b10,2'b00,2'b00,0));
        end
        for (int i = 0; i < q.size(); i++) begin
            bus.opcode = (i < 2) ? op : 4'($urandom_range(0, 15));
            bus.cond   = (i == 2) ? c : 1'($urandom);
            #4;
            tag = $sformatf("op%0d_cyc%0d", op, i);
            check(tag, obs, q[i]);
            check_inv({tag, "_inv"});
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_abort"}, obs, 14'd0);
                @(posedge clk);
                #1;
                check("abort_held", obs, 14'd0);
                rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst_n      = 1'b0;
        bus.opcode = 4'b0000;
        bus.cond   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", obs, 14'd0);
        bus.opcode = 4'b1010;
        #2;
        check("reset_outputs_opchg", obs, 14'd0);
        bus.opcode = 4'b0000;
        #1;
        rst_n = 1'b1;

        run_instr(4'b0000, 1'b0, -1);
        run_instr(4'b0001, 1'b0, -1);
        run_instr(4'b0100, 1'b0, -1);
        run_instr(4'b0101, 1'b0, -1);
        run_instr(4'b1001, 1'b0, -1);
        run_instr(4'b1001, 1'b1, -1);
        run_instr(4'b1000, 1'b1, -1);
        run_instr(4'b1111, 1'b1, -1);
        run_instr(4'b0011, 1'b0, -1);
        run_instr(4'b0110, 1'b0, -1);
        run_instr(4'b0111, 1'b1, -1);
        run_instr(4'b1010, 1'b0, -1);
        run_instr(4'b0010, 1'b1, -1);
        run_instr(4'b1011, 1'b0, -1);
        run_instr(4'b0001, 1'b0, 3);
        run_instr(4'b0000, 1'b1, -1);

        for (int n = 0; n < 80; n++)
            run_instr(4'($urandom_range(0, 15)), 1'($urandom), -1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
